// File: rtl/i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_req_arbiter
//
// Round-robin arbiter and sequencer that shares one I2C_Master between
// NUM_REQ on-chip requesters. The winning requester's slave address and data
// byte are captured on the grant edge and presented to the master. The
// master's start handshake is driven until busy is seen. Completion is taken
// from the falling busy flag and reported as a one-cycle done pulse, or, when
// the watchdog is built, as a one-cycle err pulse on timeout.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   : per-transaction watchdog of TIMEOUT_CYCLES clk cycles; err
//               pulses for the owning requester on expiry.
//   undefined : no watchdog logic, err tied low, START/WAIT_DONE wait forever.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (used with the watchdog only)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset
//   req        in   [NUM_REQ]    bit i high: requester i wants a transaction
//   req_addr   in   [7*NUM_REQ]  slave address of requester i at [7i+6:7i]
//   req_data   in   [8*NUM_REQ]  data byte of requester i at [8i+7:8i]
//   gnt        out  [NUM_REQ]    one-hot owner of the master
//   done       out  [NUM_REQ]    one-cycle pulse on normal completion
//   err        out  [NUM_REQ]    one-cycle pulse on watchdog abort
//   m_addr     out  [7]          slave address to I2C_Master
//   m_data     out  [8]          data byte to I2C_Master
//   m_start    out              start level to I2C_Master (start_tx)
//   m_busy     in               I2C_Master busy flag
//   idle       out              high while the FSM is in IDLE
//   dbg_state  out  [2]          current FSM state (IDLE=0, START=1,
//                                WAIT_DONE=2, DONE=3)
//
// Handshake: req[i] acts as a valid that the requester holds until it is
// served; gnt[i] is the acceptance and stays high for the whole transaction;
// done[i] (or err[i]) closes it. A requester drops req[i] in the cycle it sees
// done[i]/err[i], otherwise it is treated as a fresh request. Dropping req
// after the grant does not cancel the transaction. Toward the master, m_start
// is a valid that is held until m_busy is sampled high (the ready), and the
// transaction is complete when m_busy is next sampled low.
// -----------------------------------------------------------------------------
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    output logic                 m_start,
    input  logic                 m_busy,
    output logic                 idle,
    output logic [1:0]           dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("i2c_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [NUM_REQ-1:0] gnt_n, done_n;
    logic [6:0]         m_addr_n;
    logic [7:0]         m_data_n;
    logic               m_start_n;

    // Round-robin search: first set req bit starting just after the last
    // winner, wrapping modulo NUM_REQ. The last winner itself is checked last.
    logic [PTR_W-1:0]   win;
    logic               win_vld;
    logic [6:0]         win_addr;
    logic [7:0]         win_data;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] ptr_onehot;

    always_comb begin
        int idx;
        logic [PTR_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // Slice selection with constant offsets keeps the mux regular.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win) begin
                win_addr = req_addr[7*i +: 7];
                win_data = req_data[8*i +: 8];
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    assign ptr_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0]    wd;
    logic               wd_expired;
    logic [NUM_REQ-1:0] err_n;

    assign wd_expired = (state == START || state == WAIT_DONE) &&
                        (wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Cleared on the grant edge, counts every cycle the master is owned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (state == IDLE && win_vld) begin
            wd <= '0;
        end else if (state == START || state == WAIT_DONE) begin
            wd <= wd + WD_W'(1);
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        done_n    = '0;
        m_addr_n  = m_addr;
        m_data_n  = m_data;
        m_start_n = m_start;
`ifdef I2C_ARB_TIMEOUT_EN
        err_n     = '0;
        // Watchdog abort takes priority over a same-cycle busy transition so
        // that exactly one of done/err fires per transaction.
        if (wd_expired) begin
            m_start_n = 1'b0;
            gnt_n     = '0;
            err_n     = ptr_onehot;
            state_n   = DONE;
        end else
`endif
        begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt_n     = win_onehot;
                        m_addr_n  = win_addr;
                        m_data_n  = win_data;
                        m_start_n = 1'b1;
                        ptr_n     = win;
                        state_n   = START;
                    end
                end
                START: begin
                    if (m_busy) begin
                        m_start_n = 1'b0;
                        state_n   = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        gnt_n   = '0;
                        done_n  = ptr_onehot;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= PTR_W'(NUM_REQ - 1);
            gnt     <= '0;
            done    <= '0;
            m_addr  <= '0;
            m_data  <= '0;
            m_start <= 1'b0;
            idle    <= 1'b1;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            done    <= done_n;
            m_addr  <= m_addr_n;
            m_data  <= m_data_n;
            m_start <= m_start_n;
            idle    <= (state_n == IDLE);
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= '0;
        end else begin
            err <= err_n;
        end
    end
`else
    assign err = '0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_req_arbiter
//
// Self-checking bench for i2c_req_arbiter with NUM_REQ=4 and
// TIMEOUT_CYCLES=100. A small master model drives m_busy; a round-robin
// reference (last-winner pointer plus a modular search) predicts each grant.
// The watchdog scenario is compiled only when I2C_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 100;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic [6:0]     m_addr;
    logic [7:0]     m_data;
    logic           m_start;
    logic           m_busy;
    logic           idle;
    logic [1:0]     dbg_state;

    int errors = 0;
    int checks = 0;
    int model_ptr;   // last winner according to the reference model

    i2c_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_start   (m_start),
        .m_busy    (m_busy),
        .idle      (idle),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first requester after the last winner, wrapping around.
    function automatic int model_winner(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_slices();
        req_addr = 28'($urandom);
        req_data = $urandom;
    endtask

    // One full transaction starting in IDLE. The master model raises busy
    // after start_delay cycles of m_start and holds it for busy_len edges.
    // raise_m/drop_m alter req once the transaction is in WAIT_DONE;
    // scramble changes the address/data inputs at the same point.
    task automatic run_txn(input logic [N-1:0] r, input int exp_w,
                           input int start_delay, input int busy_len,
                           input logic [N-1:0] raise_m, input logic [N-1:0] drop_m,
                           input bit scramble);
        logic [6:0]   ea;
        logic [7:0]   ed;
        logic [N-1:0] eg;
        bit           ok;
        checks++;
        if (idle !== 1'b1 || gnt !== '0) begin
            errors++;
            $display("FAIL pre_idle: idle=%b gnt=%b required idle=1 gnt=0", idle, gnt);
        end
        req = r;
        ea  = req_addr[7*exp_w +: 7];
        ed  = req_data[8*exp_w +: 8];
        eg  = 4'b0001 << exp_w;
        step();
        model_ptr = exp_w;
        checks++;
        if (gnt !== eg) begin
            errors++;
            $display("FAIL grant: gnt=%b required %b", gnt, eg);
        end
        checks++;
        if (m_start !== 1'b1 || idle !== 1'b0 || done !== '0 || err !== '0) begin
            errors++;
            $display("FAIL grant_ctrl: m_start=%b idle=%b done=%b err=%b required 1 0 0 0",
                     m_start, idle, done, err);
        end
        checks++;
        if (m_addr !== ea || m_data !== ed) begin
            errors++;
            $display("FAIL capture: m_addr=%h m_data=%h required %h %h", m_addr, m_data, ea, ed);
        end
        ok = 1'b1;
        for (int i = 0; i < start_delay; i++) begin
            step();
            if (m_start !== 1'b1 || gnt !== eg) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_hold: m_start=%b gnt=%b required 1 %b", m_start, gnt, eg);
        end
        m_busy = 1'b1;
        step();
        checks++;
        if (m_start !== 1'b0 || gnt !== eg) begin
            errors++;
            $display("FAIL start_fall: m_start=%b gnt=%b required 0 %b", m_start, gnt, eg);
        end
        req = (req | raise_m) & ~drop_m;
        if (scramble) randomize_slices();
        ok = 1'b1;
        for (int i = 0; i < busy_len - 1; i++) begin
            step();
            if (done !== '0 || err !== '0 || gnt !== eg || m_start !== 1'b0 ||
                m_addr !== ea || m_data !== ed) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_hold: gnt=%b done=%b m_addr=%h m_data=%h required %b 0 %h %h",
                     gnt, done, m_addr, m_data, eg, ea, ed);
        end
        m_busy = 1'b0;
        step();
        checks++;
        if (done !== eg || gnt !== '0 || err !== '0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b gnt=%b err=%b idle=%b required %b 0 0 0",
                     done, gnt, err, idle, eg);
        end
        checks++;
        if (m_addr !== ea || m_data !== ed) begin
            errors++;
            $display("FAIL addr_stable: m_addr=%h m_data=%h required %h %h", m_addr, m_data, ea, ed);
        end
        step();
        checks++;
        if (done !== '0 || idle !== 1'b1 || gnt !== '0) begin
            errors++;
            $display("FAIL back_to_idle: done=%b idle=%b gnt=%b required 0 1 0", done, idle, gnt);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (gnt !== '0 || done !== '0 || err !== '0 || m_addr !== 7'h00 ||
            m_data !== 8'h00 || m_start !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL %s: gnt=%b done=%b err=%b m_addr=%h m_data=%h m_start=%b idle=%b required all 0, idle=1",
                     tag, gnt, done, err, m_addr, m_data, m_start, idle);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #12;
        check_reset_values("reset_values");
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (idle !== 1'b1 || gnt !== '0 || m_start !== 1'b0) begin
            errors++;
            $display("FAIL no_req_idle: idle=%b gnt=%b m_start=%b required 1 0 0", idle, gnt, m_start);
        end
    endtask

    task automatic test_round_robin();
        randomize_slices();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, i % N, $urandom_range(0, 2), $urandom_range(1, 5), '0, '0, 1'b0);
        end
    endtask

    task automatic test_single();
        randomize_slices();
        req_addr[13:7]  = 7'h11;
        req_data[15:8]  = 8'hA5;
        run_txn(4'b0010, 1, 2, 20, '0, '0, 1'b0);
        req = '0;
    endtask

    task automatic test_hog();
        randomize_slices();
        // Requester 0 keeps asking; requester 2 arrives mid-transaction.
        run_txn(4'b0001, 0, 1, 6, 4'b0100, '0, 1'b0);
        run_txn(4'b0101, 2, 0, 3, '0, '0, 1'b0);
        run_txn(4'b0101, 0, 0, 2, '0, '0, 1'b0);
        req = '0;
    endtask

    task automatic test_drop();
        randomize_slices();
        run_txn(4'b0010, 1, 0, 10, '0, 4'b0010, 1'b1);
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        for (int n = 0; n < 25; n++) begin
            randomize_slices();
            r = 4'($urandom_range(1, 15));
            run_txn(r, model_winner(r), $urandom_range(0, 3), $urandom_range(1, 8),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        req = '0;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        randomize_slices();
        m_busy = 1'b0;
        req    = 4'b0001;
        step();
        model_ptr = 0;
        checks++;
        if (gnt !== 4'b0001 || m_start !== 1'b1) begin
            errors++;
            $display("FAIL to_grant: gnt=%b m_start=%b required 0001 1", gnt, m_start);
        end
        ok = 1'b1;
        for (int i = 1; i < TO; i++) begin
            step();
            if (err !== '0 || done !== '0 || m_start !== 1'b1 || gnt !== 4'b0001) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_early: err=%b done=%b m_start=%b required 0 0 1 until cycle %0d",
                     err, done, m_start, TO);
        end
        step();
        checks++;
        if (err !== 4'b0001 || done !== '0 || m_start !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL to_abort: err=%b done=%b m_start=%b gnt=%b required 0001 0 0 0",
                     err, done, m_start, gnt);
        end
        req = '0;
        step();
        checks++;
        if (err !== '0 || done !== '0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL to_recover: err=%b done=%b idle=%b required 0 0 1", err, done, idle);
        end
        run_txn(4'b0100, 2, 1, 4, '0, '0, 1'b0);
        req = '0;
    endtask
`endif

    task automatic test_async_reset();
        randomize_slices();
        req = 4'b0100;
        step();
        m_busy = 1'b1;
        step();
        step();
        checks++;
        if (gnt !== 4'b0100 || m_start !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: gnt=%b m_start=%b required 0100 0", gnt, m_start);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        m_busy = 1'b0;
        req    = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        model_ptr = N - 1;
        run_txn(4'b1111, 0, 1, 3, '0, '0, 1'b0);
        req = '0;
    endtask

    // ---------------- main ----------------
    initial begin
        rst       = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_data  = '0;
        m_busy    = 1'b0;
        model_ptr = N - 1;
        test_reset();
        test_round_robin();
        test_single();
        test_hog();
        test_drop();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one I2C_Master between up to NUM_REQ on-chip requesters. It captures the winning requester's 7-bit slave address and 8-bit data byte and drives the master's start handshake. It watches the master's busy flag to detect completion and returns a per-requester done or error pulse. It sits between client logic (sensor pollers, config loaders) and the single I2C_Master instance driving SCL/SDA.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 500000: watchdog limit in clk cycles per transaction (only with the watchdog compiled in).
- clk  in  1  system clock, 50 MHz, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  requester i holds bit i high to request a transaction.
- req_addr  in  7*NUM_REQ  packed slave addresses; slice i = bits [7i+6:7i].
- req_data  in  8*NUM_REQ  packed data bytes; slice i = bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot; bit i high while requester i owns the master.
- done  out  NUM_REQ  one-cycle pulse on normal completion for requester i.
- err  out  NUM_REQ  one-cycle pulse on watchdog abort for requester i.
- m_addr  out  7  slave address to I2C_Master.
- m_data  out  8  data byte to I2C_Master.
- m_start  out  1  start level to I2C_Master (its start_tx).
- m_busy  in  1  high while I2C_Master is executing a transaction.
- idle  out  1  high when the FSM is in IDLE.

## Operation
- All outputs are registered. Reset values: gnt=0, done=0, err=0, m_addr=0, m_data=0, m_start=0, idle=1, state=IDLE, ptr=NUM_REQ-1, watchdog=0.
- States: IDLE, START, WAIT_DONE, DONE.
- IDLE: if req≠0, the winner is the first set bit searching ptr+1, ptr+2, … with wrap modulo NUM_REQ. On the same edge: set gnt to one-hot winner, latch m_addr/m_data from the winner's slices, set m_start=1, ptr←winner, go to START. If req=0, stay in IDLE.
- START: hold m_start=1 until m_busy is sampled high, then m_start←0 and go to WAIT_DONE.
- WAIT_DONE: when m_busy is sampled low, gnt←0, done[winner]←1, go to DONE.
- DONE: done←0, go to IDLE. This gives exactly one cycle of idle=1 between back-to-back transactions.
- m_addr/m_data are stable from the grant edge until the next grant; later changes on req_addr/req_data are ignored.
- A requester dropping req after grant does not abort: the transaction completes and done still pulses. Requesters must drop req on the cycle they see done, or they re-request.
- Only one of done or err pulses per transaction, never both.
- An asynchronous reset in any state forces the reset values immediately. Bus recovery is the master's responsibility.

## Timing
- req high before edge k (in IDLE) → gnt and m_start high after edge k.
- m_start falls 1 cycle after m_busy is first sampled high.
- done pulses 1 cycle after m_busy is sampled low in WAIT_DONE. gnt falls on the same edge.
- Minimum period per transaction = 3 + (busy-high cycles) + 1 IDLE.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on grant and increments every cycle in START and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: m_start←0, gnt←0, err[winner]←1, go to DONE. In that case done stays 0 for the transaction.
- I2C_ARB_TIMEOUT_EN undefined:
  - No counter logic is built.
  - err is tied to 0.
  - START and WAIT_DONE wait indefinitely.

## Test plan
- Single requester: req=4'b0010, req_addr slice1=7'h11, req_data slice1=8'hA5, with a master model asserting busy for 20 cycles → gnt=4'b0010 and m_addr=7'h11, m_data=8'hA5 after the edge, one done[1] pulse, idle returns.
- Simultaneous requests: req=4'b1111 held, re-asserted after each done → grants in order 0,1,2,3,0. Each gnt is one-hot, with one IDLE cycle between grants.
- Fairness with a hog: req[0] always high, req[2] raised during requester 0's transaction → next grant goes to 2, not 0.
- Requester 1 drops req during WAIT_DONE → the transaction completes, done[1] pulses, m_addr is unchanged.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, and a master that never raises busy → err[0] pulses 100 cycles after the grant, m_start=0, done stays 0, and the FSM accepts a new request.
- rst pulsed low mid-WAIT_DONE → all outputs return to reset values asynchronously. The first grant after release goes to requester 0.
